// File: rtl/alu_pkg.sv
// Shared constants and types for the registered ALU: unit selects, per-unit opcodes,
// default widths and compare result codes.
package alu_pkg;

    // Default widths
    localparam int unsigned DEF_IN_DATA_WIDTH   = 16;
    localparam int unsigned DEF_ARITH_OUT_WIDTH = 32;
    localparam int unsigned DEF_LOGIC_OUT_WIDTH = 16;
    localparam int unsigned DEF_SHIFT_OUT_WIDTH = 16;
    localparam int unsigned DEF_CMP_OUT_WIDTH   = 3;

    // Unit select, taken from ALU_FUNC[3:2]
    typedef enum logic [1:0] {
        ARITH = 2'b00,
        LOGIC = 2'b01,
        CMP   = 2'b10,
        SHIFT = 2'b11
    } unit_e;

    // One-hot enable bit positions
    localparam int unsigned EN_ARITH = 0;
    localparam int unsigned EN_LOGIC = 1;
    localparam int unsigned EN_CMP   = 2;
    localparam int unsigned EN_SHIFT = 3;

    // Arithmetic opcodes
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Logic opcodes
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    // Compare opcodes
    localparam logic [1:0] OP_CNOP = 2'b00;
    localparam logic [1:0] OP_CEQ  = 2'b01;
    localparam logic [1:0] OP_CGT  = 2'b10;
    localparam logic [1:0] OP_CLT  = 2'b11;

    // Shift opcodes
    localparam logic [1:0] OP_ASHR = 2'b00;
    localparam logic [1:0] OP_ASHL = 2'b01;
    localparam logic [1:0] OP_BSHR = 2'b10;
    localparam logic [1:0] OP_BSHL = 2'b11;

    // Compare result codes
    localparam logic [2:0] CMP_NONE = 3'd0;
    localparam logic [2:0] CMP_EQ   = 3'd1;
    localparam logic [2:0] CMP_GT   = 3'd2;
    localparam logic [2:0] CMP_LT   = 3'd3;

endpackage

// File: rtl/alu_decoder.sv
// Maps the unit-select field of the function code to four one-hot unit enables.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [1:0] unit_sel_i,
    output logic [3:0] unit_en_o
);

    // Exactly one enable is driven high for every select value
    always_comb begin
        unit_en_o = '0;
        unique case (unit_sel_i)
            ARITH:   unit_en_o[EN_ARITH] = 1'b1;
            LOGIC:   unit_en_o[EN_LOGIC] = 1'b1;
            CMP:     unit_en_o[EN_CMP]   = 1'b1;
            default: unit_en_o[EN_SHIFT] = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_top.sv
// Registered 16-bit ALU with arithmetic, logic, compare and shift units. One unit is active
// per cycle; its result and flag are registered, all other unit outputs register as zero.
// Optional divider is compiled in when ALU_DIV_EN is defined; otherwise op 0011 yields 0.
module alu_top
    import alu_pkg::*;
#(
    parameter int unsigned IN_DATA_WIDTH   = DEF_IN_DATA_WIDTH,
    parameter int unsigned ARITH_OUT_WIDTH = DEF_ARITH_OUT_WIDTH,
    parameter int unsigned LOGIC_OUT_WIDTH = DEF_LOGIC_OUT_WIDTH,
    parameter int unsigned SHIFT_OUT_WIDTH = DEF_SHIFT_OUT_WIDTH,
    parameter int unsigned CMP_OUT_WIDTH   = DEF_CMP_OUT_WIDTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [IN_DATA_WIDTH-1:0]   A,
    input  logic [IN_DATA_WIDTH-1:0]   B,
    input  logic [3:0]                 ALU_FUNC,
    output logic [ARITH_OUT_WIDTH-1:0] Arith_OUT,
    output logic                       Carry_OUT,
    output logic                       Arith_Flag,
    output logic [LOGIC_OUT_WIDTH-1:0] Logic_OUT,
    output logic                       Logic_Flag,
    output logic [CMP_OUT_WIDTH-1:0]   CMP_OUT,
    output logic                       CMP_Flag,
    output logic [SHIFT_OUT_WIDTH-1:0] Shift_OUT,
    output logic                       Shift_Flag
);

    logic [3:0] unit_en;

    alu_decoder u_decoder (
        .unit_sel_i (ALU_FUNC[3:2]),
        .unit_en_o  (unit_en)
    );

    logic [1:0]                 op;
    logic [IN_DATA_WIDTH:0]     sum;
    logic [IN_DATA_WIDTH-1:0]   a_shl;
    logic [IN_DATA_WIDTH-1:0]   b_shl;

    logic [ARITH_OUT_WIDTH-1:0] arith_d, arith_q;
    logic                       carry_d, carry_q;
    logic [LOGIC_OUT_WIDTH-1:0] logic_d, logic_q;
    logic [CMP_OUT_WIDTH-1:0]   cmp_d, cmp_q;
    logic [SHIFT_OUT_WIDTH-1:0] shift_d, shift_q;
    logic [3:0]                 flags_q;

    assign op    = ALU_FUNC[1:0];
    assign sum   = {1'b0, A} + {1'b0, B};
    // Left shifts drop the MSB so the result stays at operand width
    assign a_shl = {A[IN_DATA_WIDTH-2:0], 1'b0};
    assign b_shl = {B[IN_DATA_WIDTH-2:0], 1'b0};

    // Compute the selected unit's result; every other unit's next value stays zero
    always_comb begin
        arith_d = '0;
        carry_d = 1'b0;
        logic_d = '0;
        cmp_d   = '0;
        shift_d = '0;
        unique case (1'b1)
            unit_en[EN_ARITH]: begin
                unique case (op)
                    OP_ADD: begin
                        arith_d = ARITH_OUT_WIDTH'(sum);
                        carry_d = sum[IN_DATA_WIDTH];
                    end
                    OP_SUB: begin
                        arith_d = ARITH_OUT_WIDTH'(A) - ARITH_OUT_WIDTH'(B);
                        carry_d = (A < B);
                    end
                    OP_MUL: arith_d = ARITH_OUT_WIDTH'(A) * ARITH_OUT_WIDTH'(B);
                    default: begin
`ifdef ALU_DIV_EN
                        arith_d = (B == '0) ? '0 : ARITH_OUT_WIDTH'(A / B);
`else
                        arith_d = '0;
`endif
                    end
                endcase
            end
            unit_en[EN_LOGIC]: begin
                unique case (op)
                    OP_AND:  logic_d = LOGIC_OUT_WIDTH'(A & B);
                    OP_OR:   logic_d = LOGIC_OUT_WIDTH'(A | B);
                    OP_NAND: logic_d = LOGIC_OUT_WIDTH'(~(A & B));
                    default: logic_d = LOGIC_OUT_WIDTH'(~(A | B));
                endcase
            end
            unit_en[EN_CMP]: begin
                unique case (op)
                    OP_CNOP: cmp_d = CMP_OUT_WIDTH'(CMP_NONE);
                    OP_CEQ:  cmp_d = (A == B) ? CMP_OUT_WIDTH'(CMP_EQ) : CMP_OUT_WIDTH'(CMP_NONE);
                    OP_CGT:  cmp_d = (A > B)  ? CMP_OUT_WIDTH'(CMP_GT) : CMP_OUT_WIDTH'(CMP_NONE);
                    default: cmp_d = (A < B)  ? CMP_OUT_WIDTH'(CMP_LT) : CMP_OUT_WIDTH'(CMP_NONE);
                endcase
            end
            default: begin
                unique case (op)
                    OP_ASHR: shift_d = SHIFT_OUT_WIDTH'(A >> 1);
                    OP_ASHL: shift_d = SHIFT_OUT_WIDTH'(a_shl);
                    OP_BSHR: shift_d = SHIFT_OUT_WIDTH'(B >> 1);
                    default: shift_d = SHIFT_OUT_WIDTH'(b_shl);
                endcase
            end
        endcase
    end

    // Output registers; synchronous reset clears results and flags and discards the op
    always_ff @(posedge CLK) begin
        if (RST) begin
            arith_q <= '0;
            carry_q <= 1'b0;
            logic_q <= '0;
            cmp_q   <= '0;
            shift_q <= '0;
            flags_q <= '0;
        end else begin
            arith_q <= arith_d;
            carry_q <= carry_d;
            logic_q <= logic_d;
            cmp_q   <= cmp_d;
            shift_q <= shift_d;
            flags_q <= unit_en;
        end
    end

    assign Arith_OUT  = arith_q;
    assign Carry_OUT  = carry_q;
    assign Arith_Flag = flags_q[EN_ARITH];
    assign Logic_OUT  = logic_q;
    assign Logic_Flag = flags_q[EN_LOGIC];
    assign CMP_OUT    = cmp_q;
    assign CMP_Flag   = flags_q[EN_CMP];
    assign Shift_OUT  = shift_q;
    assign Shift_Flag = flags_q[EN_SHIFT];

endmodule

// File: tb/tb_alu_top.sv
// Scoreboard bench for alu_top: the driver pushes hand-computed expected outputs as each
// operation is issued, and a monitor pops and compares one entry per clock after the edge.
module tb_alu_top;

    typedef struct packed {
        logic [31:0] arith;
        logic        carry;
        logic        af;
        logic [15:0] lg;
        logic        lf;
        logic [2:0]  cmp;
        logic        cf;
        logic [15:0] sh;
        logic        sf;
    } res_t;

`ifdef ALU_DIV_EN
    localparam logic [31:0] DIV_150_10 = 32'd15;
`else
    localparam logic [31:0] DIV_150_10 = 32'd0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  ALU_FUNC = '0;
    logic [31:0] Arith_OUT;
    logic        Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
    logic [15:0] Logic_OUT, Shift_OUT;
    logic [2:0]  CMP_OUT;

    res_t  act;
    res_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    alu_top dut (
        .CLK        (CLK),
        .RST        (RST),
        .A          (A),
        .B          (B),
        .ALU_FUNC   (ALU_FUNC),
        .Arith_OUT  (Arith_OUT),
        .Carry_OUT  (Carry_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_OUT  (Logic_OUT),
        .Logic_Flag (Logic_Flag),
        .CMP_OUT    (CMP_OUT),
        .CMP_Flag   (CMP_Flag),
        .Shift_OUT  (Shift_OUT),
        .Shift_Flag (Shift_Flag)
    );

    always #5 CLK = ~CLK;

    assign act = {Arith_OUT, Carry_OUT, Arith_Flag, Logic_OUT, Logic_Flag,
                  CMP_OUT, CMP_Flag, Shift_OUT, Shift_Flag};

    function automatic res_t r_zero();
        return '0;
    endfunction

    function automatic res_t r_arith(logic [31:0] v, logic c);
        res_t r = '0;
        r.arith = v; r.carry = c; r.af = 1'b1;
        return r;
    endfunction

    function automatic res_t r_logic(logic [15:0] v);
        res_t r = '0;
        r.lg = v; r.lf = 1'b1;
        return r;
    endfunction

    function automatic res_t r_cmp(logic [2:0] v);
        res_t r = '0;
        r.cmp = v; r.cf = 1'b1;
        return r;
    endfunction

    function automatic res_t r_shift(logic [15:0] v);
        res_t r = '0;
        r.sh = v; r.sf = 1'b1;
        return r;
    endfunction

    // Drive one operation away from the sampling edge and record what must appear after it
    task automatic issue(input string nm, input logic rst, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] fn, input res_t e);
        @(negedge CLK);
        RST      = rst;
        A        = a;
        B        = b;
        ALU_FUNC = fn;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: each edge retires the oldest outstanding operation
    initial begin
        res_t  e;
        string nm;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
            end
        end
    end

    initial begin
        // Reset overrides an active add
        issue("reset",       1'b1, 16'd15,     16'd10, 4'b0000, r_zero());
        issue("add_15_10",   1'b0, 16'd15,     16'd10, 4'b0000, r_arith(32'd25, 1'b0));
        issue("sub_15_10",   1'b0, 16'd15,     16'd10, 4'b0001, r_arith(32'd5, 1'b0));
        issue("mul_15_10",   1'b0, 16'd15,     16'd10, 4'b0010, r_arith(32'd150, 1'b0));
        issue("div_150_10",  1'b0, 16'd150,    16'd10, 4'b0011, r_arith(DIV_150_10, 1'b0));
        issue("sub_3_5",     1'b0, 16'd3,      16'd5,  4'b0001, r_arith(32'hFFFF_FFFE, 1'b1));
        issue("add_ffff_1",  1'b0, 16'hFFFF,   16'd1,  4'b0000, r_arith(32'h0001_0000, 1'b1));
        issue("div_by_0",    1'b0, 16'd150,    16'd0,  4'b0011, r_arith(32'd0, 1'b0));
        issue("mul_max",     1'b0, 16'hFFFF,   16'hFFFF, 4'b0010, r_arith(32'hFFFE_0001, 1'b0));
        issue("and",         1'b0, 16'h0009,   16'h0003, 4'b0100, r_logic(16'h0001));
        issue("or",          1'b0, 16'h0009,   16'h0003, 4'b0101, r_logic(16'h000B));
        issue("nand",        1'b0, 16'h0009,   16'h0003, 4'b0110, r_logic(16'hFFFE));
        issue("nor",         1'b0, 16'h0009,   16'h0003, 4'b0111, r_logic(16'hFFF4));
        issue("cmp_nop",     1'b0, 16'd9,      16'd3,  4'b1000, r_cmp(3'd0));
        issue("cmp_eq_ne",   1'b0, 16'd9,      16'd3,  4'b1001, r_cmp(3'd0));
        issue("cmp_gt",      1'b0, 16'd9,      16'd3,  4'b1010, r_cmp(3'd2));
        issue("cmp_lt_no",   1'b0, 16'd9,      16'd3,  4'b1011, r_cmp(3'd0));
        issue("cmp_eq_7",    1'b0, 16'd7,      16'd7,  4'b1001, r_cmp(3'd1));
        issue("cmp_gt_7",    1'b0, 16'd7,      16'd7,  4'b1010, r_cmp(3'd0));
        issue("cmp_lt_3_9",  1'b0, 16'd3,      16'd9,  4'b1011, r_cmp(3'd3));
        issue("shr_a",       1'b0, 16'd9,      16'd3,  4'b1100, r_shift(16'd4));
        issue("shl_a",       1'b0, 16'd9,      16'd3,  4'b1101, r_shift(16'd18));
        issue("shr_b",       1'b0, 16'd9,      16'd3,  4'b1110, r_shift(16'd1));
        issue("shl_b",       1'b0, 16'd9,      16'd3,  4'b1111, r_shift(16'd6));
        issue("shl_a_trunc", 1'b0, 16'h8001,   16'd3,  4'b1101, r_shift(16'h0002));
        issue("shr_b_msb",   1'b0, 16'd9,      16'h8001, 4'b1110, r_shift(16'h4000));
        // Back-to-back unit changes, then a mid-stream reset discarding a multiply
        issue("b2b_add",     1'b0, 16'd100,    16'd200, 4'b0000, r_arith(32'd300, 1'b0));
        issue("b2b_nor",     1'b0, 16'h00F0,   16'h0F00, 4'b0111, r_logic(16'hF00F));
        issue("b2b_shl",     1'b0, 16'h4000,   16'd0,  4'b1101, r_shift(16'h8000));
        issue("b2b_lt",      1'b0, 16'd1,      16'd2,  4'b1011, r_cmp(3'd3));
        issue("mid_reset",   1'b1, 16'd300,    16'd300, 4'b0010, r_zero());
        issue("after_rst",   1'b0, 16'd300,    16'd300, 4'b0010, r_arith(32'd90000, 1'b0));
        issue("b2b_sub",     1'b0, 16'd0,      16'd1,  4'b0001, r_arith(32'hFFFF_FFFF, 1'b1));
        issue("b2b_and",     1'b0, 16'hFFFF,   16'h1234, 4'b0100, r_logic(16'h1234));

        // Bounded drain of the scoreboard
        begin
            int cycles = 0;
            while (exp_q.size() > 0 && cycles < 10) begin
                @(posedge CLK);
                cycles++;
            end
            @(posedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain: %0d outstanding, expected 0", exp_q.size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
